// File: rtl/iiitb_pwm_pkg.sv
// Shared PWM types, default duty widths and saturating duty arithmetic.
// Used by the duty controller and the PWM generator.
package iiitb_pwm_pkg;

   localparam int unsigned PWM_DUTY_W    = 4;
   localparam int unsigned PWM_DUTY_MAX  = 10;
   localparam int unsigned PWM_DUTY_INIT = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RAMP  = 2'd1,
      FAULT = 2'd2
   } state_t;

   // One step up or down, computed one bit wider so neither 0 nor max_val wraps.
   function automatic logic [PWM_DUTY_W-1:0] sat_step(
      input logic [PWM_DUTY_W-1:0] val,
      input logic                  up,
      input logic [PWM_DUTY_W-1:0] max_val
   );
      logic [PWM_DUTY_W:0] wide;
      if (up) begin
         wide = {1'b0, val} + (PWM_DUTY_W+1)'(1);
         if (wide > {1'b0, max_val}) wide = {1'b0, max_val};
      end else begin
         wide = {1'b0, val} - (PWM_DUTY_W+1)'(1);
         if (wide[PWM_DUTY_W]) wide = '0;
      end
      return wide[PWM_DUTY_W-1:0];
   endfunction

   function automatic logic [PWM_DUTY_W-1:0] clamp_duty(
      input logic [PWM_DUTY_W-1:0] val,
      input logic [PWM_DUTY_W-1:0] max_val
   );
      return (val > max_val) ? max_val : val;
   endfunction

endpackage

// File: rtl/iiitb_pwm_step_timer.sv
// Counts PWM period boundaries while enabled and flags every STEP_PERIODS-th one.
module iiitb_pwm_step_timer #(
   parameter int unsigned STEP_PERIODS = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   input  logic period_start,
   output logic step_tick_c
);

   localparam int unsigned      CNT_W = 4;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEP_PERIODS - 1);

   logic [CNT_W-1:0] step_cnt;

   assign step_tick_c = enable & period_start & (step_cnt == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         step_cnt <= '0;
      end else if (clear) begin
         step_cnt <= '0;
      end else if (enable & period_start) begin
         step_cnt <= step_tick_c ? '0 : step_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/iiitb_pwm_duty_ctrl.sv
// Duty controller: arbitrates host/button targets and ramps the PWM duty at period boundaries.
// Define IIITB_PWM_FAULT_EN to add the fault/fault_clr inputs and the FAULT state.
module iiitb_pwm_duty_ctrl
   import iiitb_pwm_pkg::*;
#(
   parameter int unsigned DUTY_W       = PWM_DUTY_W,
   parameter int unsigned DUTY_MAX     = PWM_DUTY_MAX,
   parameter int unsigned DUTY_INIT    = PWM_DUTY_INIT,
   parameter int unsigned STEP_PERIODS = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              period_start,
   input  logic              tgt_valid,
   input  logic [DUTY_W-1:0] tgt_duty,
   output logic              tgt_ready,
   input  logic              inc_pulse,
   input  logic              dec_pulse,
`ifdef IIITB_PWM_FAULT_EN
   input  logic              fault,
   input  logic              fault_clr,
`endif
   output logic [DUTY_W-1:0] duty_out,
   output logic              duty_upd,
   output logic              busy,
   output logic [DUTY_W-1:0] target_out
);

   localparam logic [PWM_DUTY_W-1:0] MAX_P  = PWM_DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0]     INIT_D = DUTY_W'(DUTY_INIT);

   state_t            state_q, state_nxt;
   logic [DUTY_W-1:0] target_nxt, duty_nxt;
   logic              upd_nxt;
   logic              host_acc;
   logic              ramp_active;
   logic              step_tick_c;

   assign ramp_active = (state_q == RAMP);

   iiitb_pwm_step_timer #(
      .STEP_PERIODS (STEP_PERIODS)
   ) u_step_timer (
      .clk          (clk),
      .reset_n      (reset_n),
      .clear        (!ramp_active),
      .enable       (ramp_active),
      .period_start (period_start),
      .step_tick_c  (step_tick_c)
   );

   // Target arbitration, then FSM next state and duty step.
   always_comb begin
      state_nxt  = state_q;
      target_nxt = target_out;
      duty_nxt   = duty_out;
      upd_nxt    = 1'b0;
      host_acc   = tgt_valid & tgt_ready;

      if (host_acc) begin
         target_nxt = DUTY_W'(clamp_duty(PWM_DUTY_W'(tgt_duty), MAX_P));
      end else if (inc_pulse & ~dec_pulse) begin
         target_nxt = DUTY_W'(sat_step(PWM_DUTY_W'(target_out), 1'b1, MAX_P));
      end else if (dec_pulse & ~inc_pulse) begin
         target_nxt = DUTY_W'(sat_step(PWM_DUTY_W'(target_out), 1'b0, MAX_P));
      end

      case (state_q)
         IDLE: begin
            // Look at the incoming target so an accept at t lands in RAMP at t+1.
            if (target_nxt != duty_out) state_nxt = RAMP;
         end
         RAMP: begin
            if (duty_out == target_out) begin
               state_nxt = IDLE;
            end else if (step_tick_c) begin
               duty_nxt = DUTY_W'(sat_step(PWM_DUTY_W'(duty_out), duty_out < target_out, MAX_P));
               upd_nxt  = 1'b1;
            end
         end
`ifdef IIITB_PWM_FAULT_EN
         FAULT: begin
            target_nxt = target_out;
            if (fault_clr) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase

`ifdef IIITB_PWM_FAULT_EN
      // Fault forces zero duty immediately, without waiting for a period boundary.
      if (fault) begin
         state_nxt  = FAULT;
         duty_nxt   = '0;
         target_nxt = '0;
         upd_nxt    = (state_q != FAULT);
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         duty_out   <= INIT_D;
         target_out <= INIT_D;
         duty_upd   <= 1'b0;
         busy       <= 1'b0;
         tgt_ready  <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         duty_out   <= duty_nxt;
         target_out <= target_nxt;
         duty_upd   <= upd_nxt;
         busy       <= (state_nxt == RAMP);
         tgt_ready  <= (state_nxt != FAULT);
      end
   end

endmodule

// File: tb/tb_iiitb_pwm_duty_ctrl.sv
// Self-checking bench for iiitb_pwm_duty_ctrl: directed steps plus random traffic
// compared each cycle against a behavioural model of the target/ramp rules.
module tb_iiitb_pwm_duty_ctrl;

   localparam int STEP    = 2;
   localparam int PWM_LEN = 10;
   localparam int DMAX    = 10;
   localparam int DINIT   = 5;

   logic       clk, reset_n, period_start, tgt_valid, tgt_ready;
   logic       inc_pulse, dec_pulse, duty_upd, busy, fault, fault_clr;
   logic [3:0] tgt_duty, duty_out, target_out;

   int tests = 0;
   int fails = 0;
   int phase = 0;
   int cyc_n = 0;
   logic last_ps = 1'b0;
   int last_upd = -1;

   // Behavioural model state
   int m_tgt, m_duty, m_cnt;
   bit m_ramp, m_upd, m_ready, m_fault;

   iiitb_pwm_duty_ctrl #(
      .DUTY_W       (4),
      .DUTY_MAX     (DMAX),
      .DUTY_INIT    (DINIT),
      .STEP_PERIODS (STEP)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .period_start (period_start),
      .tgt_valid    (tgt_valid),
      .tgt_duty     (tgt_duty),
      .tgt_ready    (tgt_ready),
      .inc_pulse    (inc_pulse),
      .dec_pulse    (dec_pulse),
`ifdef IIITB_PWM_FAULT_EN
      .fault        (fault),
      .fault_clr    (fault_clr),
`endif
      .duty_out     (duty_out),
      .duty_upd     (duty_upd),
      .busy         (busy),
      .target_out   (target_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input int exp);
      tests++;
      assert (obs === 8'(exp)) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_tgt = DINIT; m_duty = DINIT; m_cnt = 0;
      m_ramp = 0; m_upd = 0; m_ready = 0; m_fault = 0;
   endtask

   // One clock of the controller's rules, applied to the model.
   task automatic model_step(input logic v, input int d, input logic inc, input logic dec,
                             input logic ps, input logic f, input logic fc);
      int old_t, new_t;
      old_t = m_tgt;
      m_upd = 0;
      if (f) begin
         m_upd = !m_fault;
         m_tgt = 0; m_duty = 0; m_fault = 1; m_ramp = 0; m_cnt = 0; m_ready = 0;
         return;
      end
      if (m_fault) begin
         if (fc) begin m_fault = 0; m_ready = 1; end
         return;
      end
      if (v && m_ready)       new_t = (d > DMAX) ? DMAX : d;
      else if (inc && !dec)   new_t = (old_t + 1 > DMAX) ? DMAX : old_t + 1;
      else if (dec && !inc)   new_t = (old_t == 0) ? 0 : old_t - 1;
      else                    new_t = old_t;
      if (!m_ramp) begin
         if (new_t != m_duty) begin m_ramp = 1; m_cnt = 0; end
      end else if (m_duty == old_t) begin
         m_ramp = 0; m_cnt = 0;
      end else if (ps) begin
         m_cnt++;
         if (m_cnt == STEP) begin
            m_cnt = 0;
            m_duty = m_duty + ((old_t > m_duty) ? 1 : -1);
            m_upd = 1;
         end
      end
      m_tgt = new_t;
      m_ready = 1;
   endtask

   task automatic cyc(input logic v, input logic [3:0] d, input logic inc, input logic dec,
                      input logic f, input logic fc);
      tgt_valid = v; tgt_duty = d; inc_pulse = inc; dec_pulse = dec;
      fault = f; fault_clr = fc;
      period_start = (phase == 0);
      last_ps = period_start;
      model_step(v, int'(d), inc, dec, period_start, f, fc);
      @(posedge clk); #1;
      phase = (phase + 1) % PWM_LEN;
      cyc_n++;
      chk("duty_out", duty_out, m_duty);
      chk("target_out", target_out, m_tgt);
      chk("duty_upd", duty_upd, int'(m_upd));
      chk("busy", busy, int'(m_ramp));
      chk("tgt_ready", tgt_ready, int'(m_ready));
   endtask

   task automatic idle();
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic settle();
      for (int i = 0; i < 300 && (m_ramp || m_duty != m_tgt); i++) idle();
      chk("settled_busy", busy, 0);
   endtask

   task automatic watch_gap();
      if (duty_upd) begin
         if (last_upd >= 0) chk("step_gap", 8'(cyc_n - last_upd), STEP * PWM_LEN);
         last_upd = cyc_n;
      end
   endtask

   initial begin
      int psn, nupd;
      reset_n = 1'b1; period_start = 0; tgt_valid = 0; tgt_duty = 0;
      inc_pulse = 0; dec_pulse = 0; fault = 0; fault_clr = 0;

      // Reset values
      #3 reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_duty", duty_out, DINIT);
      chk("rst_target", target_out, DINIT);
      chk("rst_busy", busy, 0);
      chk("rst_upd", duty_upd, 0);
      chk("rst_ready", tgt_ready, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      #1 chk("release_ready_low", tgt_ready, 0);
      idle();
      chk("release_ready_high", tgt_ready, 1);
      repeat (3) idle();

      // Host ramp 5 -> 8
      cyc(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ramp_busy", busy, 1);
      psn = 0; nupd = 0;
      for (int i = 0; i < 70; i++) begin
         idle();
         if (duty_upd) nupd++;
         if (last_ps) begin
            psn++;
            if (psn == 2 || psn == 4 || psn == 6) chk("ramp_up_step", duty_out, DINIT + psn / 2);
         end
      end
      chk("ramp_up_upd_count", 8'(nupd), 3);
      chk("ramp_up_final", duty_out, 8);
      chk("ramp_up_idle", busy, 0);

      // Clamping and saturation
      cyc(1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("clamp_15", target_out, 10);
      repeat (3) cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("inc_sat_max", target_out, 10);
      repeat (12) cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("dec_sat_zero", target_out, 0);
      cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("inc_dec_same", target_out, 1);
      cyc(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("host_beats_button", target_out, 2);
      settle();

      // Mid-ramp reversal 5 -> 9, turn back to 3 at duty 7
      cyc(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      settle();
      last_upd = -1;
      cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 120 && m_duty != 7; i++) begin idle(); watch_gap(); end
      chk("rev_reach7", duty_out, 7);
      cyc(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      watch_gap();
      for (int i = 0; i < 200 && (m_ramp || m_duty != 3); i++) begin idle(); watch_gap(); end
      chk("rev_final", duty_out, 3);

      // Async reset in the middle of a ramp
      cyc(1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 60 && m_duty == 3; i++) idle();
      chk("pre_reset_moved", duty_out, 4);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_duty", duty_out, DINIT);
      chk("async_rst_target", target_out, DINIT);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_ready", tgt_ready, 0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      #1;
      idle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), 1'b0, 1'b0);
      end
      settle();

`ifdef IIITB_PWM_FAULT_EN
      // Fault during a ramp at duty 7
      cyc(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      settle();
      cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 120 && m_duty != 7; i++) idle();
      chk("flt_pre_duty", duty_out, 7);
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("flt_duty0", duty_out, 0);
      chk("flt_ready0", tgt_ready, 0);
      chk("flt_upd", duty_upd, 1);
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("flt_clr_held", tgt_ready, 0);
      cyc(1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("flt_ignore_in", target_out, 0);
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("flt_exit_ready", tgt_ready, 1);
      chk("flt_exit_duty", duty_out, 0);
      chk("flt_exit_busy", busy, 0);
      repeat (3) idle();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/iiitb_pwm_duty_ctrl.md
Name: iiitb_pwm_duty_ctrl

Overview:
- Duty-cycle controller that sits in front of the PWM generator and owns its duty setting.
- Arbitrates between two sources: a host target load with a valid/ready handshake, and debounced button inc/dec pulses.
- Ramps the applied duty toward the target, one step every STEP_PERIODS PWM periods.
- Duty changes only at PWM period boundaries, so the PWM output never glitches.

Parameters:
- DUTY_W, 4: width of duty values.
- DUTY_MAX, 10: maximum duty code; the PWM period is 10 counts.
- DUTY_INIT, 5: duty and target value at reset (50%).
- STEP_PERIODS, 2: PWM periods per ramp step; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- period_start  in  1  one-cycle pulse from the PWM generator when its period counter wraps to 0.
- tgt_valid  in  1  host target request.
- tgt_duty  in  DUTY_W  requested target; values above DUTY_MAX clamp to DUTY_MAX.
- tgt_ready  out  1  controller can accept a target.
- inc_pulse  in  1  debounced single-cycle button pulse, +1 to target.
- dec_pulse  in  1  debounced single-cycle button pulse, -1 to target.
- duty_out  out  DUTY_W  applied duty to the PWM generator; registered.
- duty_upd  out  1  one-cycle strobe, high in the cycle duty_out takes a new value.
- busy  out  1  high while ramping.
- target_out  out  DUTY_W  current target; registered.

Behaviour:
- Reset (reset_n=0, async):
  - duty_out=target_out=DUTY_INIT.
  - step_cnt=0, state=IDLE, duty_upd=0, busy=0.
  - tgt_ready=0 while reset_n is low; tgt_ready=1 from the first clock after release.
- Target arbitration, evaluated each cycle, in priority order:
  1. Host accept (tgt_valid & tgt_ready): target <= min(tgt_duty, DUTY_MAX). Button pulses in the same cycle are dropped.
  2. inc_pulse & ~dec_pulse: target <= target+1, saturating at DUTY_MAX.
  3. dec_pulse & ~inc_pulse: target <= target-1, saturating at 0.
  4. inc & dec together: no change.
- tgt_ready is 1 in IDLE and RAMP, so a new target may replace the target mid-ramp.
- FSM IDLE:
  - busy=0.
  - If target_out != duty_out: go to RAMP next cycle, step_cnt <= 0.
- FSM RAMP:
  - busy=1.
  - On period_start with step_cnt < STEP_PERIODS-1: step_cnt++.
  - On period_start with step_cnt == STEP_PERIODS-1: step_cnt <= 0; duty_out moves one step toward the target value of that cycle (+1 if below, -1 if above); duty_upd=1 in the following cycle, aligned with the new duty_out.
  - When registered duty_out == target_out: go to IDLE. This check is independent of period_start.
  - Target changed mid-ramp: ramp direction follows the new target; step_cnt is not restarted.
  - Target changed back to the current duty mid-ramp: go to IDLE with no duty change.
- Outside a step, duty_out is held and duty_upd=0.
- period_start outside RAMP is ignored; step_cnt holds at 0.
- Latency: a target accepted at cycle t puts the FSM in RAMP at t+1. The first duty step occurs on the STEP_PERIODS-th period_start after that; period_start at t+1 counts.
- Widths:
  - step_cnt is 4 bits.
  - Arithmetic is done unsigned in DUTY_W+1 bits, then clamped, so there is no wrap at 0 or DUTY_MAX.

Optional Feature:
- Macro: IIITB_PWM_FAULT_EN.
- With the macro: adds input fault (sync, active-high) and input fault_clr (one-cycle pulse), plus state FAULT.
  - fault=1 in any state: next cycle duty_out=0, target_out=0, duty_upd=1, state FAULT. The update is immediate and does not wait for period_start.
  - In FAULT: tgt_ready=0, button pulses ignored, busy=0.
  - Exit FAULT to IDLE on fault_clr only when fault=0; duty and target stay 0.
  - fault has priority over every other input.
- Without the macro: no fault ports, no FAULT state.

Decomposition:
- Package iiitb_pwm_pkg holds:
  - state encoding (IDLE=2'd0, RAMP=2'd1, FAULT=2'd2);
  - DUTY_W, DUTY_MAX and DUTY_INIT defaults;
  - the saturating inc/dec function, shared with the PWM generator.
- One sub-module, iiitb_pwm_step_timer: counts period_start pulses and emits step_tick. It has clear/enable inputs and the STEP_PERIODS parameter.

Test Plan:
- Reset release: duty_out=5, target_out=5, busy=0, tgt_ready=1 one cycle after reset_n rises; duty_upd never pulses.
- Host ramp up, STEP_PERIODS=2, target 8 from duty 5:
  - duty_out = 6, 7, 8 on period_start #2, #4, #6;
  - exactly 3 duty_upd pulses;
  - busy falls the cycle after duty reaches 8.
- Clamping:
  - tgt_duty=15 sets target_out=10;
  - 3 inc_pulses at target 10 leave it at 10;
  - 12 dec_pulses from 10 stop at 0;
  - inc+dec in the same cycle leave target unchanged.
- Simultaneous sources: tgt_valid with tgt_duty=2 plus inc_pulse in the same cycle gives target_out=2.
- Mid-ramp reversal and reset:
  - target 9 from 5, then target 3 after duty reaches 7: duty goes 7→6→...→3 with step spacing unchanged.
  - Async reset_n low mid-ramp: duty returns to 5 immediately, without waiting for clk.
- Fault (IIITB_PWM_FAULT_EN defined), during a ramp at duty 7:
  - fault=1 gives duty_out=0 next cycle and tgt_ready=0.
  - fault_clr while fault=1 has no effect.
  - fault_clr after fault=0 returns to IDLE with duty 0.
